// File: rtl/approx_adder_error_monitor_if.sv
// approx_adder_error_monitor_if: sample stream from an adder under test into the error monitor.
// Signals:
//   in_valid  sample present on in_a/in_b/in_sum (master -> slave)
//   in_ready  monitor can accept a sample          (slave -> master)
//   in_a      operand A                            (master -> slave)
//   in_b      operand B                            (master -> slave)
//   in_sum    approximate N-bit sum                (master -> slave)
interface approx_adder_error_monitor_if #(
    parameter int N = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [N-1:0] in_sum;
    modport master (output in_valid, in_a, in_b, in_sum, input in_ready);
    modport slave  (input in_valid, in_a, in_b, in_sum, output in_ready);
endinterface

// File: rtl/approx_adder_error_monitor.sv
// approx_adder_error_monitor: windowed error statistics for an approximate adder's output stream.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           one-cycle pulse opening a window (accepted in IDLE or DONE only)
//   num_samples     window length, sampled on the accepted start
//   bus             sample stream (slave side of approx_adder_error_monitor_if)
//   busy, done      window in progress / statistics final
//   sample_count    samples accepted in this window
//   err_count       samples with nonzero error distance
//   acc_ed, max_ed  saturating ED sum, largest ED
//   acc_ovf         sticky accumulator saturation flag
//   acc_sq          saturating ED^2 sum (only when SQERR_EN is defined)
// Optional feature macro: SQERR_EN.
module approx_adder_error_monitor #(
    parameter int N     = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48,
    parameter int SQ_W  = 80
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [CNT_W-1:0]          num_samples,
    approx_adder_error_monitor_if.slave bus,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          sample_count,
    output logic [CNT_W-1:0]          err_count,
    output logic [ACC_W-1:0]          acc_ed,
    output logic [N:0]                max_ed,
    output logic                      acc_ovf
`ifdef SQERR_EN
    ,
    output logic [SQ_W-1:0]           acc_sq
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] target;
    logic             v1, v2;
    logic [N:0]       s1_exact, s1_sum, s2_ed, ed;
    logic [ACC_W:0]   acc_nx;
    logic             xfer, sat;
    assign bus.in_ready = (state == RUN) && (sample_count < target);
    assign xfer         = bus.in_valid && bus.in_ready;
    assign ed           = s1_exact >= s1_sum ? s1_exact - s1_sum : s1_sum - s1_exact;
    // one extra bit catches the carry that signals saturation
    assign acc_nx       = {1'b0, acc_ed} + {{(ACC_W-N){1'b0}}, s2_ed};
`ifdef SQERR_EN
    logic [2*N+1:0] sq;
    logic [SQ_W:0]  sq_nx;
    assign sq    = s2_ed * s2_ed;
    assign sq_nx = {1'b0, acc_sq} + {{(SQ_W-2*N-1){1'b0}}, sq};
    assign sat   = acc_nx[ACC_W] | sq_nx[SQ_W];
`else
    assign sat   = acc_nx[ACC_W];
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            target       <= '0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            s1_exact     <= '0;
            s1_sum       <= '0;
            s2_ed        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_count <= '0;
            err_count    <= '0;
            acc_ed       <= '0;
            max_ed       <= '0;
            acc_ovf      <= 1'b0;
`ifdef SQERR_EN
            acc_sq       <= '0;
`endif
        end else begin
            v1 <= xfer;
            v2 <= v1;
            if (xfer) begin
                s1_exact     <= {1'b0, bus.in_a} + {1'b0, bus.in_b};
                s1_sum       <= {1'b0, bus.in_sum};
                sample_count <= sample_count + CNT_W'(1);
            end
            if (v1)
                s2_ed <= ed;
            if (v2) begin
                err_count <= err_count + CNT_W'(s2_ed != '0);
                acc_ed    <= acc_nx[ACC_W] ? '1 : acc_nx[ACC_W-1:0];
                max_ed    <= s2_ed > max_ed ? s2_ed : max_ed;
                acc_ovf   <= acc_ovf | sat;
`ifdef SQERR_EN
                acc_sq    <= sq_nx[SQ_W] ? '1 : sq_nx[SQ_W-1:0];
`endif
            end
            // the pipeline is empty in IDLE/DONE, so these clears never race a stats update
            if ((state == IDLE || state == DONE) && start) begin
                state        <= num_samples == '0 ? DONE : RUN;
                target       <= num_samples;
                busy         <= num_samples != '0;
                done         <= num_samples == '0;
                sample_count <= '0;
                err_count    <= '0;
                acc_ed       <= '0;
                max_ed       <= '0;
                acc_ovf      <= 1'b0;
`ifdef SQERR_EN
                acc_sq       <= '0;
`endif
            end else if (state == RUN && xfer && sample_count + CNT_W'(1) == target) begin
                state <= DRAIN;
            end else if (state == DRAIN && !v1 && !v2) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// tb_approx_adder_error_monitor: randomized self-checking bench against a sample-list reference model.
module tb_approx_adder_error_monitor;
    localparam int N = 16, CNT_W = 32, ACC_W = 48, SQ_W = 80;
    localparam longint ACC_LIM = (longint'(1) << ACC_W) - 1;
    logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_start = 1'b0;
    logic [CNT_W-1:0] num_samples = '0, s_num = '0;
    logic             busy, done, acc_ovf, s_busy, s_done, s_ovf;
    logic [CNT_W-1:0] sample_count, err_count, s_cnt, s_err;
    logic [ACC_W-1:0] acc_ed;
    logic [16:0]      s_acc;
    logic [N:0]       max_ed, s_max;
`ifdef SQERR_EN
    logic [SQ_W-1:0]  acc_sq, s_sq;
`endif
    int               n_checks = 0, n_errs = 0;
    longint           m_cnt, m_err, m_acc, m_max, m_sq;
    bit               m_ovf;
    approx_adder_error_monitor_if #(.N(N)) bus ();
    approx_adder_error_monitor_if #(.N(N)) sbus ();
    always #5 clk = ~clk;
    approx_adder_error_monitor #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W), .SQ_W(SQ_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .bus(bus),
        .busy(busy), .done(done), .sample_count(sample_count), .err_count(err_count),
        .acc_ed(acc_ed), .max_ed(max_ed), .acc_ovf(acc_ovf)
`ifdef SQERR_EN
        , .acc_sq(acc_sq)
`endif
    );
    approx_adder_error_monitor #(.N(N), .CNT_W(CNT_W), .ACC_W(17), .SQ_W(SQ_W)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .num_samples(s_num), .bus(sbus),
        .busy(s_busy), .done(s_done), .sample_count(s_cnt), .err_count(s_err),
        .acc_ed(s_acc), .max_ed(s_max), .acc_ovf(s_ovf)
`ifdef SQERR_EN
        , .acc_sq(s_sq)
`endif
    );
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic model_clr();
        m_cnt = 0; m_err = 0; m_acc = 0; m_max = 0; m_sq = 0; m_ovf = 0;
    endtask
    task automatic model_add(input int a, input int b, input int s);
        int e;
        e = a + b - s;
        if (e < 0) e = -e;
        m_cnt++;
        if (e != 0) m_err++;
        m_acc += e;
        if (m_acc > ACC_LIM) begin m_acc = ACC_LIM; m_ovf = 1; end
        if (e > m_max) m_max = e;
        m_sq += longint'(e) * e;
    endtask
    task automatic check_stats(input string tag);
        check({tag, ".sample_count"}, sample_count, m_cnt);
        check({tag, ".err_count"}, err_count, m_err);
        check({tag, ".acc_ed"}, acc_ed, m_acc);
        check({tag, ".max_ed"}, max_ed, m_max);
        check({tag, ".acc_ovf"}, acc_ovf, m_ovf);
`ifdef SQERR_EN
        check({tag, ".acc_sq"}, acc_sq, m_sq);
`endif
    endtask
    task automatic start_win(input int n);
        num_samples = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s, input int gaps);
        bus.in_valid = 1'b0;
        repeat (gaps) tick();
        bus.in_a = a; bus.in_b = b; bus.in_sum = s; bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
        check("send.ready", bus.in_ready, 1'b1);
        model_add(a, b, s);
        tick();
        bus.in_valid = 1'b0;
    endtask
    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && !done; i++) tick();
        check({tag, ".done"}, done, 1'b1);
    endtask
    task automatic rand_send();
        logic [15:0] a, b, s;
        int k;
        a = 16'($urandom);
        b = 16'($urandom);
        k = $urandom_range(0, 2);
        s = k == 0 ? a + b : k == 1 ? a + b + 16'($urandom_range(0, 31)) - 16'd16 : 16'($urandom);
        send(a, b, s, $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
    endtask
    initial begin
        int nx;
        bit drain_rdy;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_sum = '0;
        sbus.in_valid = 1'b0; sbus.in_a = '0; sbus.in_b = '0; sbus.in_sum = '0;
        repeat (3) tick();
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.in_ready", bus.in_ready, 1'b0);
        model_clr();
        check_stats("rst");
        rst_n = 1'b1;
        tick();
        // mixed window with the documented sample values
        model_clr();
        start_win(3);
        send(16'h1234, 16'h5678, 16'h68AC, 0);
        send(16'h1234, 16'h5678, 16'h68A0, 0);
        check("mix.busy", busy, 1'b1);
        send(16'hFFFF, 16'h0001, 16'h0000, 0);
        tick();
        tick();
        check("mix.done_early", done, 1'b0);
        tick();
        check("mix.done_lat3", done, 1'b1);
        check("mix.busy_off", busy, 1'b0);
        check("mix.err_count", err_count, 2);
        check("mix.acc_ed", acc_ed, 65548);
        check("mix.max_ed", max_ed, 65536);
        check("mix.sample_count", sample_count, 3);
`ifdef SQERR_EN
        check("mix.acc_sq", acc_sq, 80'd4294967440);
`endif
        check_stats("mix");
        // backpressure: valid held outside RUN, then 4 samples offered to a 2-sample window
        model_clr();
        bus.in_a = 16'($urandom); bus.in_b = 16'($urandom); bus.in_sum = 16'($urandom);
        bus.in_valid = 1'b1;
        repeat (3) tick();
        check("bp.idle_ready", bus.in_ready, 1'b0);
        check("bp.idle_count", sample_count, 3);
        start_win(2);
        nx = 0;
        drain_rdy = 0;
        for (int i = 0; i < 12; i++) begin
            bit x;
            x = bus.in_valid && bus.in_ready;
            if (nx == 2 && busy && bus.in_ready) drain_rdy = 1;
            if (x) begin model_add(bus.in_a, bus.in_b, bus.in_sum); nx++; end
            tick();
            if (x) begin
                bus.in_a = 16'($urandom); bus.in_b = 16'($urandom); bus.in_sum = 16'($urandom);
                bus.in_valid = nx < 4;
            end
        end
        bus.in_valid = 1'b0;
        check("bp.transfers", nx, 2);
        check("bp.drain_ready", drain_rdy, 1'b0);
        check("bp.done_ready", bus.in_ready, 1'b0);
        check("bp.done", done, 1'b1);
        check_stats("bp");
        // zero-length window
        model_clr();
        start_win(0);
        check("zero.done", done, 1'b1);
        check("zero.busy", busy, 1'b0);
        check_stats("zero");
        tick();
        check("zero.busy2", busy, 1'b0);
        // saturation on the narrow-accumulator instance
        s_num = 2;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        sbus.in_a = 16'hFFFF; sbus.in_b = 16'h0001; sbus.in_sum = 16'h0000; sbus.in_valid = 1'b1;
        tick();
        tick();
        sbus.in_valid = 1'b0;
        repeat (4) tick();
        check("sat.done", s_done, 1'b1);
        check("sat.acc_ed", s_acc, 131071);
        check("sat.acc_ovf", s_ovf, 1'b1);
        check("sat.max_ed", s_max, 65536);
        check("sat.count", s_cnt, 2);
        check("sat.err", s_err, 2);
        // start during RUN must not retarget the window
        model_clr();
        start_win(4);
        rand_send();
        rand_send();
        start_win(1);
        check("irq.busy", busy, 1'b1);
        rand_send();
        rand_send();
        wait_done("irq");
        check_stats("irq");
        // reset in the middle of a window
        start_win(5);
        rand_send();
        rand_send();
        rst_n = 1'b0;
        tick();
        model_clr();
        check("mrst.busy", busy, 1'b0);
        check("mrst.done", done, 1'b0);
        check("mrst.ready", bus.in_ready, 1'b0);
        check_stats("mrst");
        rst_n = 1'b1;
        tick();
        check("mrst.idle_ready", bus.in_ready, 1'b0);
        model_clr();
        start_win(3);
        repeat (3) rand_send();
        wait_done("fresh");
        check_stats("fresh");
        // long randomized window
        model_clr();
        start_win(1000);
        repeat (1000) rand_send();
        wait_done("rand");
        check_stats("rand");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
